// File: rtl/mem_arbiter.sv
// Two-requester (core / host) arbiter in front of a single-port RAM with 1-cycle read latency.
// Optional: define ARB_HOST_LOCK_EN to add host_lock, which masks cpu_req while high.
module mem_arbiter #(
  parameter int d_addr_bits = 6,
  parameter int data_bits   = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef ARB_HOST_LOCK_EN
  input  logic                   host_lock,
`endif
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [d_addr_bits-1:0] cpu_addr,
  input  logic [data_bits-1:0]   cpu_wdata,
  output logic                   cpu_gnt,
  output logic                   cpu_rvalid,
  output logic [data_bits-1:0]   cpu_rdata,
  input  logic                   host_req,
  input  logic                   host_we,
  input  logic [d_addr_bits-1:0] host_addr,
  input  logic [data_bits-1:0]   host_wdata,
  output logic                   host_gnt,
  output logic                   host_rvalid,
  output logic [data_bits-1:0]   host_rdata,
  output logic                   mem_we,
  output logic [d_addr_bits-1:0] mem_addr,
  output logic [data_bits-1:0]   mem_wdata,
  input  logic [data_bits-1:0]   mem_rdata,
  output logic                   busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic ID_CPU  = 1'b0;
  localparam logic ID_HOST = 1'b1;

  logic [1:0]             r_state;
  logic                   r_win;
  logic                   r_last;
  logic                   r_we;
  logic [d_addr_bits-1:0] r_addr;
  logic [data_bits-1:0]   r_wdata;
  logic [data_bits-1:0]   r_cpu_rdata;
  logic [data_bits-1:0]   r_host_rdata;
  logic                   r_cpu_rvalid;
  logic                   r_host_rvalid;

  logic                   w_cpu_req;
  logic                   w_pick;

`ifdef ARB_HOST_LOCK_EN
  assign w_cpu_req = cpu_req & ~host_lock;
`else
  assign w_cpu_req = cpu_req;
`endif

  // On a tie, the requester that was not granted last wins.
  always_comb begin
    w_pick = ID_CPU;
    if (w_cpu_req && host_req)
      w_pick = (r_last == ID_CPU) ? ID_HOST : ID_CPU;
    else if (host_req)
      w_pick = ID_HOST;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_win         <= ID_CPU;
      r_last        <= ID_HOST;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_cpu_rdata   <= '0;
      r_host_rdata  <= '0;
      r_cpu_rvalid  <= 1'b0;
      r_host_rvalid <= 1'b0;
    end else begin
      r_cpu_rvalid  <= 1'b0;
      r_host_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cpu_req || host_req) begin
            r_win   <= w_pick;
            r_last  <= w_pick;
            r_we    <= (w_pick == ID_HOST) ? host_we    : cpu_we;
            r_addr  <= (w_pick == ID_HOST) ? host_addr  : cpu_addr;
            r_wdata <= (w_pick == ID_HOST) ? host_wdata : cpu_wdata;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= r_we ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          // RAM output is valid one cycle after the address was presented in ISSUE.
          if (r_win == ID_HOST) begin
            r_host_rdata  <= mem_rdata;
            r_host_rvalid <= 1'b1;
          end else begin
            r_cpu_rdata  <= mem_rdata;
            r_cpu_rvalid <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Grant and write strobe decode from state so an async reset removes them at once.
  assign cpu_gnt     = (r_state == S_ISSUE) && (r_win == ID_CPU);
  assign host_gnt    = (r_state == S_ISSUE) && (r_win == ID_HOST);
  assign mem_we      = (r_state == S_ISSUE) && r_we;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign cpu_rvalid  = r_cpu_rvalid;
  assign host_rvalid = r_host_rvalid;
  assign cpu_rdata   = r_cpu_rdata;
  assign host_rdata  = r_host_rdata;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table of transactions, read-data scoreboard,
// round-robin, reset-abort and (with ARB_HOST_LOCK_EN) host-lock sequences.
module tb_mem_arbiter;
  localparam int AW = 6;
  localparam int DW = 64;

  typedef logic [DW-1:0] data_t;

  typedef struct {
    logic          host;
    logic          we;
    logic [AW-1:0] addr;
    data_t         wdata;
    data_t         exp_rd;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
`ifdef ARB_HOST_LOCK_EN
  logic          host_lock;
`endif
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  data_t         cpu_wdata, cpu_rdata;
  logic          host_req, host_we, host_gnt, host_rvalid;
  logic [AW-1:0] host_addr;
  data_t         host_wdata, host_rdata;
  logic          mem_we, busy;
  logic [AW-1:0] mem_addr;
  data_t         mem_wdata, mem_rdata;

  data_t         ram [0:(1<<AW)-1];

  int            checks = 0;
  int            errors = 0;
  data_t         exp_cpu_q[$];
  data_t         exp_host_q[$];
  data_t         last_cpu_rd;
  data_t         last_host_rd;
  vec_t          vecs [9];

  always #5 clk = ~clk;

  mem_arbiter #(.d_addr_bits(AW), .data_bits(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef ARB_HOST_LOCK_EN
    .host_lock  (host_lock),
`endif
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  // Registered-output RAM, one cycle of read latency.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Exclusivity and read-data scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cpu_gnt || host_gnt) chk("gnt_exclusive", 64'(cpu_gnt && host_gnt), 64'd0);
      if (cpu_rvalid || host_rvalid) chk("rvalid_exclusive", 64'(cpu_rvalid && host_rvalid), 64'd0);
      if (cpu_rvalid) begin
        if (exp_cpu_q.size() == 0) chk("cpu_rvalid_unexpected", 64'd1, 64'd0);
        else chk("cpu_rdata", cpu_rdata, exp_cpu_q.pop_front());
      end
      if (host_rvalid) begin
        if (exp_host_q.size() == 0) chk("host_rvalid_unexpected", 64'd1, 64'd0);
        else chk("host_rdata", host_rdata, exp_host_q.pop_front());
      end
    end
  end

  task automatic txn(input vec_t v);
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    if (v.host) begin
      host_req = 1'b1; host_we = v.we; host_addr = v.addr; host_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    @(negedge clk);
    chk("gnt_winner", 64'(v.host ? host_gnt : cpu_gnt), 64'd1);
    chk("gnt_other", 64'(v.host ? cpu_gnt : host_gnt), 64'd0);
    chk("issue_mem_we", 64'(mem_we), 64'(v.we));
    chk("issue_mem_addr", 64'(mem_addr), 64'(v.addr));
    if (v.we) chk("issue_mem_wdata", mem_wdata, v.wdata);
    cpu_req = 1'b0;
    host_req = 1'b0;
    if (!v.we) begin
      if (v.host) exp_host_q.push_back(v.exp_rd);
      else exp_cpu_q.push_back(v.exp_rd);
    end
    @(negedge clk);
    chk("gnt_one_cycle", 64'(cpu_gnt | host_gnt), 64'd0);
    chk("mem_we_one_cycle", 64'(mem_we), 64'd0);
    chk("mem_addr_hold", 64'(mem_addr), 64'(v.addr));
    if (v.we) begin
      chk("busy_after_write", 64'(busy), 64'd0);
    end else begin
      chk("busy_in_wait", 64'(busy), 64'd1);
      chk("rvalid_early", 64'(cpu_rvalid | host_rvalid), 64'd0);
      @(negedge clk);
      chk("rvalid_at_n3", 64'(v.host ? host_rvalid : cpu_rvalid), 64'd1);
      chk("busy_after_read", 64'(busy), 64'd0);
      if (v.host) last_host_rd = v.exp_rd;
      else last_cpu_rd = v.exp_rd;
    end
    chk("cpu_rdata_hold", cpu_rdata, last_cpu_rd);
    chk("host_rdata_hold", host_rdata, last_host_rd);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cpu_gnt"},  64'(cpu_gnt), 64'd0);
    chk({tag, "_host_gnt"}, 64'(host_gnt), 64'd0);
    chk({tag, "_rvalid"},   64'(cpu_rvalid | host_rvalid), 64'd0);
    chk({tag, "_mem_we"},   64'(mem_we), 64'd0);
    chk({tag, "_busy"},     64'(busy), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 64'd0);
    chk({tag, "_host_rdata"}, host_rdata, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    vec_t v;
    vecs[0] = '{1'b0, 1'b1, 6'd5,  64'h0000_0000_0000_DEAD, 64'h0};
    vecs[1] = '{1'b0, 1'b0, 6'd5,  64'h0,                   64'h0000_0000_0000_DEAD};
    vecs[2] = '{1'b1, 1'b1, 6'd3,  64'h0000_0000_0000_1234, 64'h0};
    vecs[3] = '{1'b1, 1'b0, 6'd3,  64'h0,                   64'h0000_0000_0000_1234};
    vecs[4] = '{1'b1, 1'b1, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    vecs[5] = '{1'b0, 1'b0, 6'd63, 64'h0,                   64'hFFFF_FFFF_FFFF_FFFF};
    vecs[6] = '{1'b0, 1'b1, 6'd0,  64'hA5A5_5A5A_0F0F_F0F0, 64'h0};
    vecs[7] = '{1'b1, 1'b0, 6'd0,  64'h0,                   64'hA5A5_5A5A_0F0F_F0F0};
    vecs[8] = '{1'b0, 1'b0, 6'd3,  64'h0,                   64'h0000_0000_0000_1234};

    rst_n = 1'b0;
`ifdef ARB_HOST_LOCK_EN
    host_lock = 1'b0;
`endif
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    last_cpu_rd = '0;
    last_host_rd = '0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) txn(vecs[i]);

    // Both requesters held high from reset release: grants must alternate cpu, host, ...
    @(negedge clk);
    rst_n = 1'b0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 6'd10; cpu_wdata = 64'h1010;
    host_req = 1; host_we = 1; host_addr = 6'd11; host_wdata = 64'h1111;
    @(negedge clk);
    rst_n = 1'b1;
    last_cpu_rd = '0;
    last_host_rd = '0;
    n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      @(negedge clk);
      if (cpu_gnt || host_gnt) begin
        chk("rr_order_host_gnt", 64'(host_gnt), 64'(n % 2));
        n++;
      end
    end
    chk("rr_grant_count", 64'(n), 64'd6);
    cpu_req = 0;
    host_req = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rr_ram10", ram[10], 64'h1010);
    chk("rr_ram11", ram[11], 64'h1111);

    // Reset asserted in the middle of ISSUE of a cpu write must abort it.
    v = '{1'b0, 1'b1, 6'd7, 64'h7777, 64'h0};
    txn(v);
    @(negedge clk);
    cpu_req = 1; cpu_we = 1; cpu_addr = 6'd7; cpu_wdata = 64'h0BAD;
    @(negedge clk);
    chk("abort_pre_mem_we", 64'(mem_we), 64'd1);
    rst_n = 1'b0;
    cpu_req = 0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_cpu_rd = '0;
    last_host_rd = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("abort_no_gnt", 64'(cpu_gnt | host_gnt), 64'd0);
    end
    chk("abort_ram7", ram[7], 64'h7777);
    v = '{1'b0, 1'b0, 6'd7, 64'h0, 64'h7777};
    txn(v);

`ifdef ARB_HOST_LOCK_EN
    @(negedge clk);
    rst_n = 1'b0;
    host_lock = 1'b1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 6'd20; cpu_wdata = 64'h2020;
    host_req = 1; host_we = 1; host_addr = 6'd21; host_wdata = 64'h2121;
    @(negedge clk);
    rst_n = 1'b1;
    last_cpu_rd = '0;
    last_host_rd = '0;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (cpu_gnt || host_gnt) begin
        chk("lock_host_gnt", 64'(host_gnt), 64'(n < 3));
        n++;
        if (n == 3) host_lock = 1'b0;
      end
    end
    chk("lock_grant_count", 64'(n), 64'd4);
    cpu_req = 0;
    host_req = 0;
    @(negedge clk);
    @(negedge clk);
`endif

    @(negedge clk);
    chk("cpu_queue_drained", 64'(exp_cpu_q.size()), 64'd0);
    chk("host_queue_drained", 64'(exp_host_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter d_addr_bits, default 6: data-memory address width.
REQ-002 SHALL have parameter data_bits, default 64: data-memory word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports cpu_req/cpu_we  input  1 each  core access request / write-not-read.
REQ-006 SHALL have ports cpu_addr  input  d_addr_bits, and cpu_wdata  input  data_bits: core address / write data.
REQ-007 SHALL have ports cpu_gnt/cpu_rvalid  output  1 each  one-cycle grant pulse / one-cycle read-data-valid pulse.
REQ-008 SHALL have port cpu_rdata  output  data_bits  read data returned to the core.
REQ-009 SHALL have host_req, host_we, host_addr, host_wdata, host_gnt, host_rvalid, host_rdata with identical widths and meanings for the loader/debug host.
REQ-010 SHALL have ports mem_we  output  1, mem_addr  output  d_addr_bits, and mem_wdata  output  data_bits, driving the RAM.
REQ-011 SHALL have port mem_rdata  input  data_bits: RAM read data, registered in RAM (1-cycle latency).
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-014 IDLE: SHALL sample requests only in IDLE; if any req is high, latch winner id, we, addr, and wdata at the clock edge, then go to ISSUE; otherwise stay in IDLE.
REQ-015 Arbitration: single req wins; both high -> winner is the requester not granted last (round-robin); last-granted register SHALL reset to host, so cpu wins the first tie.
REQ-016 ISSUE: SHALL drive mem_addr and mem_wdata from latched values, set mem_we equal to the latched we, and pulse the winner's gnt for exactly this cycle; next state is IDLE for a write, WAIT for a read.
REQ-017 WAIT: SHALL capture mem_rdata into the winner's rdata register at the edge and assert the winner's rvalid for exactly the following cycle; next state is IDLE.
REQ-018 Latency: req in cycle N -> gnt in N+1; write occurs at end of N+1; read rvalid in N+3; write takes 2 cycles and read takes 3 cycles of IDLE-to-IDLE occupancy.
REQ-019 Requesters SHALL drop req in the cycle gnt is seen; a req still high in the following IDLE cycle SHALL be treated as a new request.
REQ-020 mem_we SHALL be high only in ISSUE for writes; mem_addr and mem_wdata SHALL hold their last values outside ISSUE.
REQ-021 rdata of each requester SHALL hold its value until that requester's next read completes; the other requester's rdata SHALL be unaffected.
REQ-022 Never SHALL both gnt outputs, or both rvalid outputs, be high in the same cycle.

Reset
REQ-023 rst_n low SHALL asynchronously force state to IDLE, all gnt/rvalid/mem_we/busy to 0, mem_addr, mem_wdata, and both rdata outputs to 0, and last-granted to host.
REQ-024 Reset during ISSUE or WAIT SHALL abort the transaction: no gnt, no rvalid, and no RAM write after reset asserts.

Configuration
REQ-025 With macro ARB_HOST_LOCK_EN defined, SHALL add input host_lock (1 bit); while host_lock is high, cpu_req SHALL be ignored in IDLE, and a transaction already in progress SHALL complete normally.
REQ-026 Without ARB_HOST_LOCK_EN, host_lock SHALL be absent and arbitration SHALL be pure round-robin.

Verification
REQ-027 After reset, cpu write addr 5 data 0xDEAD, then cpu read addr 5 -> mem_we pulses once, cpu_gnt at N+1, cpu_rvalid at N+3 with cpu_rdata=0xDEAD.
REQ-028 cpu_req and host_req both held high from reset release -> grants alternate cpu, host, cpu, host; gnts are never simultaneous.
REQ-029 Host read addr 3 (RAM holds 0x1234) while the cpu idles -> host_rdata=0x1234 with host_rvalid, cpu_rdata unchanged, and cpu_rvalid stays 0.
REQ-030 rst_n pulled low during ISSUE of a cpu write to addr 7 -> mem_we drops immediately, RAM addr 7 is unchanged, and no cpu_gnt appears after reset.
REQ-031 With ARB_HOST_LOCK_EN and host_lock=1, both requesting -> only host granted; lowering host_lock -> cpu granted next.
